ic_plru_mgr: RTL

IC_PLRU_MGR -- requirements
Module: ic_plru_mgr

---
 rtl/ic_pkg.sv | 49 ++++
 rtl/ic_plru_mgr_if.sv | 36 +++
 rtl/ic_plru_tree.sv | 28 ++
 rtl/ic_plru_mgr.sv | 120 ++++++++++++
 4 files changed

// File: rtl/ic_pkg.sv
// Shared types and tree-PLRU helpers for the I-cache replacement manager.
package ic_pkg;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  // Vectors are carried at the 16-way width; callers pass the real WAYS.
  function automatic logic [3:0] plru_victim(
    input logic [14:0] st,
    input int          ways
  );
    int node;
    node = 0;
    for (int l = 0; l < 4; l++)
      if (node < ways - 1)
        node = st[node[3:0]] ? 2 * node + 2 : 2 * node + 1;
    return 4'(node - (ways - 1));
  endfunction

  function automatic logic [14:0] plru_touch(
    input logic [14:0] st,
    input logic [3:0]  w,
    input int          ways
  );
    logic [14:0] t;
    int n;
    int p;
    t = st;
    n = int'(w) + ways - 1;
    for (int l = 0; l < 4; l++)
      if (n > 0) begin
        p = (n - 1) >> 1;
        t[p[3:0]] = n[0];
        n = p;
      end
    return t;
  endfunction

endpackage

// File: rtl/ic_plru_mgr_if.sv
// Lookup / victim / touch bundle between the cache and the PLRU manager.
interface ic_plru_mgr_if
  import ic_pkg::*;
#(
  parameter int WAYS  = 4,
  parameter int LINES = 256
);
  localparam int LW = clog2(LINES);
  localparam int WW = clog2(WAYS);

  logic          lk_valid;
  logic          lk_ready;
  logic [LW-1:0] lk_line;
  logic          vic_valid;
  logic [WW-1:0] vic_way;
  logic          upd_valid;
  logic          upd_ready;
  logic [LW-1:0] upd_line;
  logic [WW-1:0] upd_way;
  logic          init_done;

  modport master (
    output lk_valid, lk_line,
    output upd_valid, upd_line, upd_way,
    input  lk_ready, upd_ready,
    input  vic_valid, vic_way, init_done
  );

  modport slave (
    input  lk_valid, lk_line,
    input  upd_valid, upd_line, upd_way,
    output lk_ready, upd_ready,
    output vic_valid, vic_way, init_done
  );

endinterface

// File: rtl/ic_plru_tree.sv
// Combinational tree-PLRU victim select and touch update for one line.
module ic_plru_tree
  import ic_pkg::*;
#(
  parameter int WAYS = 4
) (
  input  logic [WAYS-2:0]          st,
  input  logic [clog2(WAYS)-1:0]   way,
  output logic [clog2(WAYS)-1:0]   victim,
  output logic [WAYS-2:0]          touched
);

  localparam int WW = clog2(WAYS);

  logic [14:0] st_x;
  logic [14:0] t_x;
  logic [3:0]  v_x;
  logic        unused_bits;

  assign st_x    = 15'(st);
  assign v_x     = plru_victim(st_x, WAYS);
  assign t_x     = plru_touch(st_x, 4'(way), WAYS);
  assign victim  = v_x[WW-1:0];
  assign touched = t_x[WAYS-2:0];

  assign unused_bits = ^{v_x, t_x};

endmodule

// File: rtl/ic_plru_mgr.sv
// Tree-PLRU state manager: RAM sweep, victim lookup, 2-stage touch RMW.
// Define IC_PLRU_FWD_EN to forward stage-1 writes instead of stalling.
module ic_plru_mgr
  import ic_pkg::*;
#(
  parameter int WAYS  = 4,
  parameter int LINES = 256
) (
  input logic           clk,
  input logic           rst_n,
  ic_plru_mgr_if.slave  bus
);

  localparam int LW = clog2(LINES);
  localparam int WW = clog2(WAYS);
  localparam int SW = WAYS - 1;

  logic [SW-1:0] ram [LINES];

  state_e        state;
  logic [LW-1:0] cnt;
  logic          init_done;
  logic          vic_valid;
  logic [WW-1:0] vic_way;
  logic          s1_valid;
  logic [LW-1:0] s1_line;
  logic [SW-1:0] s1_vec;

  logic          run;
  logic          lk_hit;
  logic          upd_hit;
  logic          lk_fire;
  logic          upd_fire;
  logic [LW-1:0] rd_line;
  logic [SW-1:0] rd_vec;
  logic [WW-1:0] victim;
  logic [SW-1:0] touched;
  logic          we;
  logic [LW-1:0] wa;
  logic [SW-1:0] wd;

  assign run = (state == ST_RUN);

`ifdef IC_PLRU_FWD_EN
  assign lk_hit  = 1'b0;
  assign upd_hit = 1'b0;
`else
  assign lk_hit  = s1_valid && (s1_line == bus.lk_line);
  assign upd_hit = s1_valid && (s1_line == bus.upd_line);
`endif

  assign bus.lk_ready  = run && !lk_hit;
  assign bus.upd_ready = run && !bus.lk_valid && !upd_hit;

  assign lk_fire  = bus.lk_valid && bus.lk_ready;
  assign upd_fire = bus.upd_valid && bus.upd_ready;
  assign rd_line  = lk_fire ? bus.lk_line : bus.upd_line;

`ifdef IC_PLRU_FWD_EN
  assign rd_vec = (s1_valid && s1_line == rd_line) ?
                  s1_vec : ram[rd_line];
`else
  assign rd_vec = ram[rd_line];
`endif

  ic_plru_tree #(
    .WAYS (WAYS)
  ) u_tree (
    .st      (rd_vec),
    .way     (bus.upd_way),
    .victim  (victim),
    .touched (touched)
  );

  // Gating on rst_n drops an in-flight stage-1 write at reset.
  assign we = rst_n && (!run || s1_valid);
  assign wa = run ? s1_line : cnt;
  assign wd = run ? s1_vec : '0;

  always_ff @(posedge clk) begin
    if (we) ram[wa] <= wd;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_INIT;
      cnt       <= '0;
      init_done <= 1'b0;
      vic_valid <= 1'b0;
      vic_way   <= '0;
      s1_valid  <= 1'b0;
      s1_line   <= '0;
      s1_vec    <= '0;
    end else begin
      vic_valid <= lk_fire;
      if (lk_fire) vic_way <= victim;
      s1_valid <= upd_fire;
      if (upd_fire) begin
        s1_line <= bus.upd_line;
        s1_vec  <= touched;
      end
      unique case (state)
        ST_INIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == LW'(LINES - 1)) begin
            state     <= ST_RUN;
            init_done <= 1'b1;
          end
        end
        ST_RUN: state <= ST_RUN;
        default: state <= ST_INIT;
      endcase
    end
  end

  assign bus.init_done = init_done;
  assign bus.vic_valid = vic_valid;
  assign bus.vic_way   = vic_way;

endmodule
